// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece codes, colour templates, shape ROM.
// Defaults for window/board geometry used by the cell scanner.
package tetris_pkg;

  localparam int WIN_D     = 4;
  localparam int COORD_D   = 5;
  localparam int BOARD_W_D = 10;
  localparam int BOARD_H_D = 20;
  localparam int CELLS_D   = 4;
  localparam int ROW_W     = $clog2(WIN_D);

  typedef enum logic [2:0] {
    P_O   = 3'd0,
    P_I   = 3'd1,
    P_Z   = 3'd2,
    P_S   = 3'd3,
    P_T   = 3'd4,
    P_J   = 3'd5,
    P_L   = 3'd6,
    P_INV = 3'd7
  } piece_t;

  localparam logic [1:0] TPL_0 = 2'b00;
  localparam logic [1:0] TPL_1 = 2'b01;
  localparam logic [1:0] TPL_2 = 2'b10;

  // 4 rotations per piece; nibble r is window row r, bit c is col c.
  localparam logic [15:0] SHAPE_ROM [0:27] = '{
    16'h6600, 16'h6600, 16'h6600, 16'h6600,
    16'h0F00, 16'h2222, 16'h0F00, 16'h2222,
    16'h6300, 16'h2640, 16'h6300, 16'h2640,
    16'h3600, 16'h4620, 16'h3600, 16'h4620,
    16'h2700, 16'h2320, 16'h7200, 16'h2620,
    16'h4700, 16'h3220, 16'h7100, 16'h2260,
    16'h1700, 16'h2230, 16'h7400, 16'h6220
  };

  localparam logic [4:0] START [0:7] = '{
    5'd0, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd0
  };

  // Rotation bits honoured per piece.
  localparam logic [1:0] ROT_MASK [0:7] = '{
    2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00
  };

  function automatic logic [1:0] tpl(piece_t p);
    logic [1:0] t;
    unique case (p)
      P_Z, P_L: t = TPL_1;
      P_S, P_J: t = TPL_2;
      default:  t = TPL_0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tetromino_row_rom.sv
// Registered (piece, rotation, row) -> WIN-bit window row, 1-cycle latency.
// Ports: clk, rst, piece, rot, row in; bits out (hit with SCANNER_ROW_SKIP_EN).
module tetromino_row_rom
  import tetris_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  piece_t           piece,
  input  logic [1:0]       rot,
  input  logic [ROW_W-1:0] row,
  output logic [WIN_D-1:0] bits
`ifdef SCANNER_ROW_SKIP_EN
  ,
  output logic             hit
`endif
);

  logic [4:0]       idx;
  logic [15:0]      shape;
  logic [WIN_D-1:0] data;

  always_comb begin
    idx   = START[piece] + {3'b000, rot & ROT_MASK[piece]};
    shape = (piece == P_INV) ? '0 : SHAPE_ROM[idx];
    data  = shape[row*WIN_D +: WIN_D];
  end

`ifdef SCANNER_ROW_SKIP_EN
  // Unregistered occupancy of the row being fetched this cycle.
  assign hit = |data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits <= '0;
    else     bits <= data;
  end

endmodule

// File: rtl/tetromino_cell_scanner.sv
// Walks a tetromino's window and streams occupied cells as board coords.
// Ports: req_* in, cell_* out (valid/ready), done/err pulses; SCANNER_ROW_SKIP_EN.
module tetromino_cell_scanner
  import tetris_pkg::*;
#(
  parameter int WIN     = WIN_D,
  parameter int COORD_W = COORD_D,
  parameter int BOARD_W = BOARD_W_D,
  parameter int BOARD_H = BOARD_H_D,
  parameter int CELLS   = CELLS_D
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_id,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic [1:0]         cell_template,
  output logic               cell_oob,
  output logic               cell_last,
  output logic               done,
  output logic               err
);

  localparam int RW = $clog2(WIN);
  localparam int SW = COORD_W + 1;
  localparam int NW = $clog2(CELLS) + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, SCAN, EMIT, DONE
  } state_t;

  state_t             state, state_n;
  piece_t             piece;
  logic [1:0]         rot;
  logic [COORD_W-1:0] ox, oy;
  logic [RW-1:0]      row, row_n;
  logic [RW-1:0]      col, col_n;
  logic [NW-1:0]      cnt, cnt_n;
  logic               err_q;
  logic               accept, load, step;
  logic [WIN-1:0]     bits;
  logic [SW-1:0]      sx, sy;
`ifdef SCANNER_ROW_SKIP_EN
  logic               hit;
`endif

  tetromino_row_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .piece (piece),
    .rot   (rot),
    .row   (row),
    .bits  (bits)
`ifdef SCANNER_ROW_SKIP_EN
    ,
    .hit   (hit)
`endif
  );

  assign sx = {1'b0, ox} + SW'(col);
  assign sy = {1'b0, oy} + SW'(row);

  assign req_ready  = (state == IDLE);
  assign cell_valid = (state == EMIT);
  assign done       = (state == DONE);
  assign err        = done & err_q;

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    cnt_n   = cnt;
    accept  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          row_n   = '0;
          col_n   = '0;
          cnt_n   = '0;
          state_n = (req_id[4:2] == P_INV) ? DONE : FETCH;
        end
      end
      FETCH: begin
        col_n   = '0;
        state_n = SCAN;
`ifdef SCANNER_ROW_SKIP_EN
        if (!hit) begin
          if (row == RW'(WIN-1)) begin
            state_n = DONE;
          end else begin
            row_n   = row + 1'b1;
            state_n = FETCH;
          end
        end
`endif
      end
      SCAN: begin
        if (bits[col]) begin
          load    = 1'b1;
          state_n = EMIT;
        end else begin
          step = 1'b1;
        end
      end
      EMIT: begin
        if (cell_ready) begin
          cnt_n = cnt + 1'b1;
          step  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Shared column/row advance for an empty column or a taken cell.
    if (step) begin
      if (col == RW'(WIN-1)) begin
        col_n = '0;
        if (row == RW'(WIN-1)) begin
          state_n = DONE;
        end else begin
          row_n   = row + 1'b1;
          state_n = FETCH;
        end
      end else begin
        col_n   = col + 1'b1;
        state_n = SCAN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= '0;
      col           <= '0;
      cnt           <= '0;
      piece         <= P_O;
      rot           <= '0;
      ox            <= '0;
      oy            <= '0;
      err_q         <= 1'b0;
      cell_x        <= '0;
      cell_y        <= '0;
      cell_template <= '0;
      cell_oob      <= 1'b0;
      cell_last     <= 1'b0;
    end else begin
      row <= row_n;
      col <= col_n;
      cnt <= cnt_n;
      if (accept) begin
        piece <= piece_t'(req_id[4:2]);
        rot   <= req_id[1:0];
        ox    <= req_x;
        oy    <= req_y;
        err_q <= (req_id[4:2] == P_INV);
      end
      if (load) begin
        cell_x        <= sx[COORD_W-1:0];
        cell_y        <= sy[COORD_W-1:0];
        cell_template <= tpl(piece);
        cell_oob      <= (sx >= SW'(BOARD_W)) ||
                         (sy >= SW'(BOARD_H));
        cell_last     <= (cnt == NW'(CELLS-1));
      end
    end
  end

endmodule

// File: tb/tb_tetromino_cell_scanner.sv
// Self-checking bench for tetromino_cell_scanner.
// Table of requests with hand-derived cells, plus reset/backpressure cases.
module tb_tetromino_cell_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_id;
  logic [4:0] req_x;
  logic [4:0] req_y;
  logic       cell_valid;
  logic       cell_ready;
  logic [4:0] cell_x;
  logic [4:0] cell_y;
  logic [1:0] cell_template;
  logic       cell_oob;
  logic       cell_last;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tetromino_cell_scanner dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_id        (req_id),
    .req_x         (req_x),
    .req_y         (req_y),
    .cell_valid    (cell_valid),
    .cell_ready    (cell_ready),
    .cell_x        (cell_x),
    .cell_y        (cell_y),
    .cell_template (cell_template),
    .cell_oob      (cell_oob),
    .cell_last     (cell_last),
    .done          (done),
    .err           (err)
  );

  typedef struct {
    logic [4:0]       id;
    logic [4:0]       x;
    logic [4:0]       y;
    int               n;
    logic [3:0][13:0] cells;
    int               err;
    int               stall;
    int               cyc;
    int               cyc_skip;
  } vec_t;

  vec_t       tv [10];
  logic [13:0] q [$];

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] cl(int x, int y, int t,
                                     int o, int l);
    return {5'(x), 5'(y), 2'(t), 1'(o), 1'(l)};
  endfunction

  function automatic vec_t mkv(
    logic [4:0] id, int x, int y, int n,
    logic [13:0] c0, logic [13:0] c1,
    logic [13:0] c2, logic [13:0] c3,
    int e, int stall, int cyc, int cyc_skip);
    vec_t v;
    v.id       = id;
    v.x        = 5'(x);
    v.y        = 5'(y);
    v.n        = n;
    v.cells    = {c3, c2, c1, c0};
    v.err      = e;
    v.stall    = stall;
    v.cyc      = cyc;
    v.cyc_skip = cyc_skip;
    return v;
  endfunction

  function automatic logic [13:0] got();
    return {cell_x, cell_y, cell_template, cell_oob, cell_last};
  endfunction

  task automatic run(input vec_t v);
    int  cyc;
    int  stalls;
    int  exp;
    bit  fin;
    bit  rdy_hi;
    for (int i = 0; i < v.n; i++) q.push_back(v.cells[i]);
`ifdef SCANNER_ROW_SKIP_EN
    exp = v.cyc_skip;
`else
    exp = v.cyc;
`endif
    cell_ready = (v.stall == 0);
    req_id     = v.id;
    req_x      = v.x;
    req_y      = v.y;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc    = 0;
    stalls = 0;
    fin    = 1'b0;
    rdy_hi = 1'b0;
    while (!fin && cyc < 300) begin
      cyc++;
      if (req_ready) rdy_hi = 1'b1;
      if (cell_valid) begin
        if (q.size() == 0) begin
          cell_ready = 1'b1;
          chk("extra_cell", 1, 0);
        end else if (stalls < v.stall) begin
          cell_ready = 1'b0;
          stalls++;
          chk("stall_hold", got(), q[0]);
        end else begin
          cell_ready = 1'b1;
          chk("cell", got(), q.pop_front());
        end
      end
      if (done) begin
        fin = 1'b1;
        chk("err_pulse", err, v.err);
        chk("scan_cycles", cyc, exp);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("finished", fin, 1);
    chk("cells_left", q.size(), 0);
    q.delete();
    chk("busy_ready", rdy_hi, 0);
    @(posedge clk); #1;
    chk("back_idle", {req_ready, done, err, cell_valid}, 4'b1000);
  endtask

  initial begin
    int n;
    int cyc;

    tv[0] = mkv(5'b10000, 3, 0, 4,
                cl(3,2,0,0,0), cl(4,2,0,0,0),
                cl(5,2,0,0,0), cl(4,3,0,0,1), 0, 0, 25, 17);
    tv[1] = mkv(5'b00100, 7, 5, 4,
                cl(7,7,0,0,0), cl(8,7,0,0,0),
                cl(9,7,0,0,0), cl(10,7,0,1,1), 0, 0, 25, 13);
    tv[2] = mkv(5'b00011, 0, 0, 4,
                cl(1,2,0,0,0), cl(2,2,0,0,0),
                cl(1,3,0,0,0), cl(2,3,0,0,1), 0, 0, 25, 17);
    tv[3] = mkv(5'b01011, 8, 17, 4,
                cl(10,18,1,1,0), cl(9,19,1,0,0),
                cl(10,19,1,1,0), cl(9,20,1,1,1), 0, 0, 25, 21);
    tv[4] = mkv(5'b11010, 30, 0, 4,
                cl(0,2,1,1,0), cl(30,3,1,1,0),
                cl(31,3,1,1,0), cl(0,3,1,1,1), 0, 0, 25, 17);
    tv[5] = mkv(5'b10111, 0, 0, 4,
                cl(1,1,2,0,0), cl(2,1,2,0,0),
                cl(1,2,2,0,0), cl(1,3,2,0,1), 0, 0, 25, 21);
    tv[6] = mkv(5'b11100, 0, 0, 0,
                14'h0, 14'h0, 14'h0, 14'h0, 1, 0, 1, 1);
    tv[7] = mkv(5'b00111, 0, 18, 4,
                cl(1,18,0,0,0), cl(1,19,0,0,0),
                cl(1,20,0,1,0), cl(1,21,0,1,1), 0, 0, 25, 25);
    tv[8] = mkv(5'b01100, 0, 0, 4,
                cl(1,2,2,0,0), cl(2,2,2,0,0),
                cl(0,3,2,0,0), cl(1,3,2,0,1), 0, 5, 30, 22);
    tv[9] = mkv(5'b10100, 2, 3, 4,
                cl(2,5,2,0,0), cl(3,5,2,0,0),
                cl(4,5,2,0,0), cl(4,6,2,0,1), 0, 0, 25, 17);

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_id     = '0;
    req_x      = '0;
    req_y      = '0;
    cell_ready = 1'b1;
    #1;
    chk("reset_flags",
        {req_ready, cell_valid, done, err}, 4'b1000);
    chk("reset_cell", got(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run(tv[i]);

    // Reset while the second J cell is being presented.
    cell_ready = 1'b1;
    req_id     = 5'b10100;
    req_x      = 5'd2;
    req_y      = 5'd3;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < 2 && cyc < 100) begin
      if (cell_valid) n++;
      if (n < 2) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("j_second_emit", n, 2);
    rst = 1'b1;
    #1;
    chk("midscan_rst_flags",
        {req_ready, cell_valid, done, err}, 4'b1000);
    chk("midscan_rst_cell", got(), 0);
    @(posedge clk); #1;
    chk("rst_no_done", {done, cell_valid}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;
    run(tv[9]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
